// File: rtl/frame_image_drawer.sv
// rtl/frame_image_drawer.sv - raster reader from image BRAM to VGA plot commands
module frame_image_drawer #(
  parameter int                 WIDTH             = 320,
  parameter int                 HEIGHT            = 240,
  parameter int                 ADDR_W            = 17,
  parameter int                 COLOR_W           = 8,
  parameter int                 X_W               = 9,
  parameter int                 Y_W               = 8,
  parameter int                 READ_LATENCY      = 1,
  parameter int                 TRANSPARENT_EN    = 0,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = 8'hE3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  output logic [ADDR_W-1:0]  rdaddress,
  input  logic [COLOR_W-1:0] q,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam longint unsigned NPIX = longint'(WIDTH) * longint'(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);

  // Size checks: the image must fit the address space and coordinate widths.
  generate
    if (NPIX > (64'd1 << ADDR_W)) begin : g_bad_npix
      $error("frame_image_drawer: WIDTH*HEIGHT exceeds 2^ADDR_W");
    end
    if (longint'(WIDTH) > (64'd1 << X_W)) begin : g_bad_width
      $error("frame_image_drawer: WIDTH exceeds 2^X_W");
    end
    if (longint'(HEIGHT) > (64'd1 << Y_W)) begin : g_bad_height
      $error("frame_image_drawer: HEIGHT exceeds 2^Y_W");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
      $error("frame_image_drawer: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [X_W-1:0]     fx_q, fx_d;
  logic [Y_W-1:0]     fy_q, fy_d;
  logic [1:0]         drain_q, drain_d;

  // Read-latency delay line: valid bit plus the coordinates of each issued read.
  logic [READ_LATENCY-1:0] pv_q;
  logic [X_W-1:0]          px_q [READ_LATENCY];
  logic [Y_W-1:0]          py_q [READ_LATENCY];

  // Last presented pixel, so x/y/colour hold between plots.
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [COLOR_W-1:0] col_q;

  logic dvalid;
  assign dvalid = pv_q[READ_LATENCY-1];

  // Control state and fetch counters.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic: raster walk with the linear address kept alongside x/y.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          fx_d    = '0;
          fy_d    = '0;
        end
      end
      S_FETCH: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = 2'(READ_LATENCY - 1);
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (fx_q == X_LAST) begin
            fx_d = '0;
            fy_d = fy_q + Y_W'(1);
          end else begin
            fx_d = fx_q + X_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Delay the issued coordinates to line up with the returning BRAM data.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pv_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= (state_q == S_FETCH);
      px_q[0] <= fx_q;
      py_q[0] <= fy_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  end

  // Capture each presented pixel so the outputs hold once the stream stops.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q   <= '0;
      y_q   <= '0;
      col_q <= '0;
    end else if (dvalid) begin
      x_q   <= px_q[READ_LATENCY-1];
      y_q   <= py_q[READ_LATENCY-1];
      col_q <= q;
    end
  end

  // Present BRAM data in the same cycle it arrives; transparent pixels skip the strobe.
  always_comb begin
    x      = dvalid ? px_q[READ_LATENCY-1] : x_q;
    y      = dvalid ? py_q[READ_LATENCY-1] : y_q;
    colour = dvalid ? q : col_q;
    plot   = dvalid && !((TRANSPARENT_EN != 0) && (q == TRANSPARENT_COLOR));
  end

  assign rdaddress = addr_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_image_drawer.sv
// tb/tb_frame_image_drawer.sv - directed self-checking bench for frame_image_drawer
module tb_frame_image_drawer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic start_s;
  logic start_b;

  logic [16:0] ra_a, ra_t, ra_b;
  logic [7:0]  q_a, q_t, q_b1, q_b;
  logic [8:0]  x_a, x_t, x_b;
  logic [7:0]  y_a, y_t, y_b;
  logic [7:0]  c_a, c_t, c_b;
  logic        plot_a, plot_t, plot_b;
  logic        busy_a, busy_t, busy_b;
  logic        done_a, done_t, done_b;

  // BRAM models: contents equal the low address byte.
  always @(posedge clk) begin
    q_a  <= ra_a[7:0];
    q_t  <= ra_t[7:0];
    q_b1 <= ra_b[7:0];
    q_b  <= q_b1;
  end

  frame_image_drawer #(.WIDTH(4), .HEIGHT(3)) u_a (
    .clock(clk), .resetn(resetn), .start(start_s), .rdaddress(ra_a), .q(q_a),
    .x(x_a), .y(y_a), .colour(c_a), .plot(plot_a), .busy(busy_a), .done(done_a));

  frame_image_drawer #(.WIDTH(4), .HEIGHT(3), .TRANSPARENT_EN(1),
                       .TRANSPARENT_COLOR(8'h05)) u_t (
    .clock(clk), .resetn(resetn), .start(start_s), .rdaddress(ra_t), .q(q_t),
    .x(x_t), .y(y_t), .colour(c_t), .plot(plot_t), .busy(busy_t), .done(done_t));

  frame_image_drawer #(.READ_LATENCY(2)) u_b (
    .clock(clk), .resetn(resetn), .start(start_b), .rdaddress(ra_b), .q(q_b),
    .x(x_b), .y(y_b), .colour(c_b), .plot(plot_b), .busy(busy_b), .done(done_b));

  int checks = 0;
  int errors = 0;
  int npix_a, npix_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected behaviour of the 4x3 instances at cycle c of a draw.
  task automatic check_small(input int c, input int rst_at);
    bit alive, inpix;
    int p;
    alive = (rst_at == 0) || (c <= rst_at);
    inpix = alive && (c >= 2) && (c <= 13);
    p     = inpix ? c - 2 : 11;
    chk($sformatf("plot_a c%0d", c), plot_a, inpix);
    chk($sformatf("plot_t c%0d", c), plot_t, inpix && (p != 5));
    chk($sformatf("busy_a c%0d", c), busy_a, alive && (c <= 13));
    chk($sformatf("busy_t c%0d", c), busy_t, alive && (c <= 13));
    chk($sformatf("done_a c%0d", c), done_a, alive && (c == 14));
    chk($sformatf("done_t c%0d", c), done_t, alive && (c == 14));
    chk($sformatf("rdaddr_a c%0d", c), ra_a, !alive ? 0 : (c <= 12 ? c - 1 : 11));
    chk($sformatf("rdaddr_t c%0d", c), ra_t, !alive ? 0 : (c <= 12 ? c - 1 : 11));
    if (!alive) begin
      chk($sformatf("x_a c%0d", c), x_a, 0);
      chk($sformatf("y_a c%0d", c), y_a, 0);
      chk($sformatf("col_a c%0d", c), c_a, 0);
    end else if (c >= 2) begin
      chk($sformatf("x_a c%0d", c), x_a, p % 4);
      chk($sformatf("y_a c%0d", c), y_a, p / 4);
      chk($sformatf("col_a c%0d", c), c_a, p);
      chk($sformatf("x_t c%0d", c), x_t, p % 4);
      chk($sformatf("y_t c%0d", c), y_t, p / 4);
      chk($sformatf("col_t c%0d", c), c_t, p);
    end
    if (plot_a === 1'b1) npix_a++;
    if (plot_t === 1'b1) npix_t++;
  endtask

  // One 4x3 draw; extra[c] drives start during cycle c, rst_at pulses reset in that cycle.
  task automatic draw(input bit pre, input logic [15:0] extra, input int rst_at);
    npix_a = 0;
    npix_t = 0;
    if (!pre) start_s = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      check_small(c, rst_at);
      start_s = extra[c];
      resetn  = !((rst_at != 0) && (c == rst_at));
    end
    chk("npix_a", npix_a, (rst_at == 0) ? 12 : 6);
    chk("npix_t", npix_t, (rst_at == 0) ? 11 : 5);
  endtask

  int first_c, last_c, done_c, done_n, npix_b, bad_b, k;
  logic [8:0] fx, lx;
  logic [7:0] fy, ly;
  logic [16:0] max_ra;

  initial begin
    resetn  = 1'b0;
    start_s = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst plot_a", plot_a, 0);
    chk("rst busy_a", busy_a, 0);
    chk("rst done_a", done_a, 0);
    chk("rst rdaddr_a", ra_a, 0);
    chk("rst plot_b", plot_b, 0);
    chk("rst rdaddr_b", ra_b, 0);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle plot_a", plot_a, 0);
      chk("idle busy_a", busy_a, 0);
      chk("idle done_a", done_a, 0);
      chk("idle rdaddr_a", ra_a, 0);
      chk("idle x_a", x_a, 0);
      chk("idle busy_b", busy_b, 0);
    end

    draw(1'b0, 16'h0000, 0);
    draw(1'b0, 16'hE008, 0);
    draw(1'b1, 16'h0000, 0);
    draw(1'b0, 16'h0000, 7);
    draw(1'b0, 16'h0000, 0);

    first_c = -1; last_c = -1; done_c = -1; done_n = 0;
    npix_b = 0; bad_b = 0; k = 0; max_ra = '0;
    fx = '0; fy = '0; lx = '0; ly = '0;
    start_b = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 76810; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (ra_b > max_ra) max_ra = ra_b;
      if (done_b === 1'b1) begin
        done_n++;
        done_c = c;
      end
      if (plot_b === 1'b1) begin
        if (first_c < 0) begin
          first_c = c;
          fx = x_b;
          fy = y_b;
        end
        last_c = c;
        lx = x_b;
        ly = y_b;
        if (x_b !== 9'(k % 320) || y_b !== 8'(k / 320) || c_b !== 8'(k % 256)) bad_b++;
        k++;
        npix_b++;
      end
    end
    chk("big first cycle", first_c, 3);
    chk("big first x", fx, 0);
    chk("big first y", fy, 0);
    chk("big last cycle", last_c, 76802);
    chk("big last x", lx, 319);
    chk("big last y", ly, 239);
    chk("big done cycle", done_c, 76803);
    chk("big done count", done_n, 1);
    chk("big max rdaddr", max_ra, 76799);
    chk("big pixel count", npix_b, 76800);
    chk("big bad pixels", bad_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
